// File: rtl/msdap_compute_sequencer_if.sv
// Read bus between the compute sequencer and the rj / coefficient / sample memory banks.
// All three memories are synchronous-read: data appears one cycle after the address.
interface msdap_compute_sequencer_if;
    logic        mem_ch;
    logic [3:0]  rj_rd_addr;
    logic [7:0]  rj_rd_data;
    logic [8:0]  coeff_rd_addr;
    logic [8:0]  coeff_rd_data;
    logic [7:0]  data_rd_addr;
    logic [15:0] data_rd_data;

    modport master (
        output mem_ch,
        output rj_rd_addr,
        output coeff_rd_addr,
        output data_rd_addr,
        input  rj_rd_data,
        input  coeff_rd_data,
        input  data_rd_data
    );

    modport slave (
        input  mem_ch,
        input  rj_rd_addr,
        input  coeff_rd_addr,
        input  data_rd_addr,
        output rj_rd_data,
        output coeff_rd_data,
        output data_rd_data
    );
endinterface

// File: rtl/msdap_compute_sequencer.sv
// Sequences the shared multiplierless MSDAP filter datapath once per frame, left then right channel.
// Latency: per channel 2 + 3*NUM_RJ + 3*sum(r_j) cycles (2 if zero flag), plus 1 output cycle.
// No backpressure: memories answer in fixed 1 cycle; start is dropped while busy.
module msdap_compute_sequencer #(
    parameter int ACC_W  = 40,
    parameter int DATA_W = 16,
    parameter int NUM_RJ = 16
) (
    input  logic                         Sclk,
    input  logic                         Reset,
    input  logic                         start,
    input  logic [7:0]                   cur_ptr,
    input  logic                         zero_flag_L,
    input  logic                         zero_flag_R,
    msdap_compute_sequencer_if.master    mem,
    output logic                         busy,
    output logic                         out_valid,
    output logic [ACC_W-1:0]             y_L,
    output logic [ACC_W-1:0]             y_R
);

    localparam int J_W    = $clog2(NUM_RJ);
    localparam int SEXT_W = ACC_W - DATA_W - 16;

    typedef enum logic [3:0] {
        IDLE,
        CH_INIT,
        RJ_RD,
        RJ_WAIT,
        C_ADDR,
        D_ADDR,
        ACC,
        SHIFT,
        CH_END,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic               mem_ch_q, mem_ch_d;
    logic [J_W-1:0]     j_q, j_d;
    logic [8:0]         coeff_ptr_q, coeff_ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   yl_hold_q, yl_hold_d;
    logic [ACC_W-1:0]   y_l_q, y_l_d;
    logic [ACC_W-1:0]   y_r_q, y_r_d;
    logic [7:0]         cur_ptr_q, cur_ptr_d;
    logic [7:0]         data_addr_q, data_addr_d;

    logic [7:0]         data_addr_now;
    logic [ACC_W-1:0]   ext;
    logic               zero_flag_cur;

    // Sample sits at bits [31:16] of the accumulator so the 16 halvings keep full precision.
    assign ext           = {{SEXT_W{mem.data_rd_data[DATA_W-1]}}, mem.data_rd_data, 16'b0};
    assign data_addr_now = cur_ptr_q - mem.coeff_rd_data[7:0];
    assign zero_flag_cur = mem_ch_q ? zero_flag_R : zero_flag_L;

    always_comb begin
        state_d     = state_q;
        mem_ch_d    = mem_ch_q;
        j_d         = j_q;
        coeff_ptr_d = coeff_ptr_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        acc_d       = acc_q;
        yl_hold_d   = yl_hold_q;
        y_l_d       = y_l_q;
        y_r_d       = y_r_q;
        cur_ptr_d   = cur_ptr_q;
        data_addr_d = data_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CH_INIT;
                    mem_ch_d    = 1'b0;
                    acc_d       = '0;
                    j_d         = '0;
                    coeff_ptr_d = '0;
                    cur_ptr_d   = cur_ptr;
                end
            end
            CH_INIT: begin
                if (zero_flag_cur) begin
                    acc_d   = '0;
                    state_d = CH_END;
                end else begin
                    state_d = RJ_RD;
                end
            end
            RJ_RD: begin
                state_d = RJ_WAIT;
            end
            RJ_WAIT: begin
                cnt_d   = mem.rj_rd_data;
                state_d = (mem.rj_rd_data == 8'd0) ? SHIFT : C_ADDR;
            end
            C_ADDR: begin
                coeff_ptr_d = coeff_ptr_q + 9'd1;
                state_d     = D_ADDR;
            end
            D_ADDR: begin
                sign_d      = mem.coeff_rd_data[8];
                data_addr_d = data_addr_now;
                state_d     = ACC;
            end
            ACC: begin
                acc_d   = sign_q ? (acc_q - ext) : (acc_q + ext);
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? SHIFT : C_ADDR;
            end
            SHIFT: begin
                acc_d   = $signed(acc_q) >>> 1;
                j_d     = j_q + 1'b1;
                state_d = (j_q == J_W'(NUM_RJ - 1)) ? CH_END : RJ_RD;
            end
            CH_END: begin
                if (!mem_ch_q) begin
                    yl_hold_d   = acc_q;
                    mem_ch_d    = 1'b1;
                    acc_d       = '0;
                    j_d         = '0;
                    coeff_ptr_d = '0;
                    state_d     = CH_INIT;
                end else begin
                    // Both results land together so y_L/y_R always belong to the same frame.
                    y_l_d   = yl_hold_q;
                    y_r_d   = acc_q;
                    state_d = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            state_q     <= IDLE;
            mem_ch_q    <= 1'b0;
            j_q         <= '0;
            coeff_ptr_q <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            yl_hold_q   <= '0;
            y_l_q       <= '0;
            y_r_q       <= '0;
            cur_ptr_q   <= '0;
            data_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_ch_q    <= mem_ch_d;
            j_q         <= j_d;
            coeff_ptr_q <= coeff_ptr_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            acc_q       <= acc_d;
            yl_hold_q   <= yl_hold_d;
            y_l_q       <= y_l_d;
            y_r_q       <= y_r_d;
            cur_ptr_q   <= cur_ptr_d;
            data_addr_q <= data_addr_d;
        end
    end

    // The sample address is presented combinationally in D_ADDR so its data returns in ACC.
    assign mem.mem_ch        = mem_ch_q;
    assign mem.rj_rd_addr    = j_q;
    assign mem.coeff_rd_addr = coeff_ptr_q;
    assign mem.data_rd_addr  = (state_q == D_ADDR) ? data_addr_now : data_addr_q;

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign y_L       = y_l_q;
    assign y_R       = y_r_q;

endmodule

// File: tb/tb_msdap_compute_sequencer.sv
// Directed bench: behavioural memories, an equation-level filter model and a per-cycle output compare.
module tb_msdap_compute_sequencer;

    logic        Sclk = 1'b0;
    logic        Reset;
    logic        start;
    logic [7:0]  cur_ptr;
    logic        zero_flag_L;
    logic        zero_flag_R;
    logic        busy;
    logic        out_valid;
    logic [39:0] y_L;
    logic [39:0] y_R;

    msdap_compute_sequencer_if mem();

    msdap_compute_sequencer dut (
        .Sclk        (Sclk),
        .Reset       (Reset),
        .start       (start),
        .cur_ptr     (cur_ptr),
        .zero_flag_L (zero_flag_L),
        .zero_flag_R (zero_flag_R),
        .mem         (mem),
        .busy        (busy),
        .out_valid   (out_valid),
        .y_L         (y_L),
        .y_R         (y_R)
    );

    always #5 Sclk = ~Sclk;

    logic [7:0]  rj_mem    [2][16];
    logic [8:0]  coeff_mem [2][512];
    logic [15:0] data_mem  [2][256];

    always @(posedge Sclk) begin
        mem.rj_rd_data    <= rj_mem[mem.mem_ch][mem.rj_rd_addr];
        mem.coeff_rd_data <= coeff_mem[mem.mem_ch][mem.coeff_rd_addr];
        mem.data_rd_data  <= data_mem[mem.mem_ch][mem.data_rd_addr];
    end

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // Equation-level model: y = (...((U1/2 + U2)/2 + ...) + U16)/2 with floor halving.
    function automatic logic [39:0] model_y(input int ch, input bit zf);
        longint     y;
        longint     u;
        int         ptr;
        logic [8:0] c;
        logic [7:0] a;
        logic [15:0] d;
        if (zf) return 40'd0;
        y   = 0;
        ptr = 0;
        for (int j = 0; j < 16; j++) begin
            u = 0;
            for (int t = 0; t < int'(rj_mem[ch][j]); t++) begin
                c   = coeff_mem[ch][ptr];
                ptr = (ptr + 1) % 512;
                a   = cur_ptr - c[7:0];
                d   = data_mem[ch][a];
                if (c[8]) u = u - longint'($signed(d)) * 65536;
                else      u = u + longint'($signed(d)) * 65536;
            end
            y = (y + u) >>> 1;
        end
        return y[39:0];
    endfunction

    function automatic int exp_cycles(input bit zl, input bit zr);
        int total;
        int s;
        total = 1;
        for (int ch = 0; ch < 2; ch++) begin
            if ((ch == 0) ? zl : zr) begin
                total += 2;
            end else begin
                s = 0;
                for (int j = 0; j < 16; j++) s += int'(rj_mem[ch][j]);
                total += 2 + 48 + 3 * s;
            end
        end
        return total;
    endfunction

    logic [39:0] exp_yl;
    logic [39:0] exp_yr;
    bit          ov_allowed = 1'b0;
    int          ov_count   = 0;
    bit          coeff_nz;
    bit          seen_fd;
    bit          seen_wrap;
    logic [8:0]  prev_ca = '0;

    // Single compare/monitor process, sampled away from the active edge.
    always @(negedge Sclk) begin
        if (out_valid === 1'b1) begin
            ov_count++;
            if (!ov_allowed) begin
                chk("unexpected_out_valid", 40'(out_valid), 40'd0);
            end else begin
                chk("y_L", y_L, exp_yl);
                chk("y_R", y_R, exp_yr);
            end
        end
        if (mem.coeff_rd_addr != 9'd0) coeff_nz = 1'b1;
        if (mem.data_rd_addr == 8'hFD) seen_fd = 1'b1;
        if (prev_ca == 9'd511 && mem.coeff_rd_addr == 9'd0) seen_wrap = 1'b1;
        prev_ca = mem.coeff_rd_addr;
    end

    task automatic clear_mems();
        for (int ch = 0; ch < 2; ch++) begin
            for (int j = 0; j < 16; j++)  rj_mem[ch][j]    = 8'd0;
            for (int i = 0; i < 512; i++) coeff_mem[ch][i] = 9'd0;
            for (int a = 0; a < 256; a++) data_mem[ch][a]  = 16'd0;
        end
    endtask

    task automatic run_frame(input string tag, input int exp_cyc,
                             input logic [39:0] eyl, input logic [39:0] eyr, input bit disturb);
        int got;
        bit busy_drop;
        exp_yl     = eyl;
        exp_yr     = eyr;
        ov_allowed = 1'b1;
        ov_count   = 0;
        coeff_nz   = 1'b0;
        seen_fd    = 1'b0;
        seen_wrap  = 1'b0;
        got        = -1;
        busy_drop  = 1'b0;
        start = 1'b1;
        @(posedge Sclk); #1;
        start = 1'b0;
        for (int c = 1; c <= exp_cyc + 50; c++) begin
            start = disturb && (c == 5 || c == exp_cyc);
            @(negedge Sclk);
            if (!busy) busy_drop = 1'b1;
            if (out_valid) begin
                got = c;
                break;
            end
            @(posedge Sclk); #1;
        end
        @(posedge Sclk); #1;
        start = 1'b0;
        @(negedge Sclk);
        chk({tag, "_cycles"}, 40'(got), 40'(exp_cyc));
        chk({tag, "_busy_held"}, 40'(busy_drop), 40'd0);
        chk({tag, "_busy_after"}, 40'(busy), 40'd0);
        chk({tag, "_out_valid_once"}, 40'(ov_count), 40'd1);
        ov_allowed = 1'b0;
    endtask

    task automatic load_unit_frame();
        clear_mems();
        cur_ptr = 8'd10;
        for (int ch = 0; ch < 2; ch++) begin
            for (int j = 0; j < 16; j++) rj_mem[ch][j] = 8'd1;
            data_mem[ch][10] = 16'h4000;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        Reset       = 1'b1;
        start       = 1'b1;
        cur_ptr     = 8'd0;
        zero_flag_L = 1'b0;
        zero_flag_R = 1'b0;
        clear_mems();
        repeat (3) @(posedge Sclk);
        @(negedge Sclk);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_out_valid", 40'(out_valid), 40'd0);
        chk("rst_mem_ch", 40'(mem.mem_ch), 40'd0);
        chk("rst_rj_addr", 40'(mem.rj_rd_addr), 40'd0);
        chk("rst_coeff_addr", 40'(mem.coeff_rd_addr), 40'd0);
        chk("rst_data_addr", 40'(mem.data_rd_addr), 40'd0);
        chk("rst_y_L", y_L, 40'd0);
        chk("rst_y_R", y_R, 40'd0);
        @(posedge Sclk); #1;
        Reset = 1'b0;
        start = 1'b0;
        @(negedge Sclk);
        chk("start_with_reset_ignored", 40'(busy), 40'd0);
        @(posedge Sclk); #1;

        // 1: r_j=1, +k0 terms, x[n]=0x4000 on both channels
        load_unit_frame();
        chk("model_pin_t1", model_y(0, 1'b0), 40'h00_3FFF_C000);
        run_frame("t1", 197, 40'h00_3FFF_C000, 40'h00_3FFF_C000, 1'b0);

        // 2: single subtracted term in U1, right channel empty
        clear_mems();
        cur_ptr          = 8'd33;
        rj_mem[0][0]     = 8'd1;
        coeff_mem[0][0]  = 9'h100;
        data_mem[0][33]  = 16'h0001;
        chk("model_pin_t2", model_y(0, 1'b0), 40'hFF_FFFF_FFFF);
        run_frame("t2", 104, 40'hFF_FFFF_FFFF, 40'd0, 1'b0);

        // 3: all r_j=0 -> zero output, no coefficient fetches
        clear_mems();
        cur_ptr = 8'd7;
        for (int a = 0; a < 256; a++) begin
            data_mem[0][a] = 16'h1234;
            data_mem[1][a] = 16'h8001;
        end
        run_frame("t3", 101, 40'd0, 40'd0, 1'b0);
        chk("t3_coeff_reads", 40'(coeff_nz), 40'd0);

        // 4: address wraps on the sample and coefficient buses
        clear_mems();
        cur_ptr = 8'd2;
        for (int j = 0; j < 16; j++) begin
            rj_mem[0][j] = (j == 15) ? 8'd40 : 8'd32;
            rj_mem[1][j] = 8'(j + 1);
        end
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < 512; i++)
                coeff_mem[ch][i] = {(i % 3 == 0), 8'((i * 13 + ch) & 255)};
            for (int a = 0; a < 256; a++) begin
                int v;
                v = ((a * 37 + ch * 5) % 2048) - 1024;
                data_mem[ch][a] = 16'(v);
            end
        end
        coeff_mem[0][0] = 9'h005;
        run_frame("t4", exp_cycles(1'b0, 1'b0), model_y(0, 1'b0), model_y(1, 1'b0), 1'b0);
        chk("t4_data_addr_wrap", 40'(seen_fd), 40'd1);
        chk("t4_coeff_addr_wrap", 40'(seen_wrap), 40'd1);

        // 5: right channel in zero run, start pulses while busy and during OUT
        load_unit_frame();
        zero_flag_R = 1'b1;
        run_frame("t5", exp_cycles(1'b0, 1'b1), model_y(0, 1'b0), 40'd0, 1'b1);
        zero_flag_R = 1'b0;
        repeat (3) @(negedge Sclk);
        chk("t5_no_restart", 40'(busy), 40'd0);

        // 6: reset during an ACC cycle of the left channel, then a clean frame
        @(posedge Sclk); #1;
        start = 1'b1;
        @(posedge Sclk); #1;
        start = 1'b0;
        repeat (17) begin
            @(posedge Sclk); #1;
        end
        Reset = 1'b1;
        @(posedge Sclk); #1;
        Reset = 1'b0;
        @(negedge Sclk);
        chk("t6_busy", 40'(busy), 40'd0);
        chk("t6_y_L", y_L, 40'd0);
        chk("t6_y_R", y_R, 40'd0);
        chk("t6_mem_ch", 40'(mem.mem_ch), 40'd0);
        chk("t6_no_out_valid", 40'(ov_count), 40'd1);
        run_frame("t6", 197, 40'h00_3FFF_C000, 40'h00_3FFF_C000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
